// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : timer_bank
//  Purpose  : Memory-mapped compare/interrupt timer. One free-running counter
//             feeds NUM_TIMERS one-shot or periodic compare channels. Each
//             channel has a pending bit and a mask bit, and together they
//             drive a single level interrupt line.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int          NUM_TIMERS = 4,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd_data,
    output logic        hit,
    output logic        irq
);

    // Architectural state
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_compare [NUM_TIMERS];
    logic [CNT_W-1:0]      r_period  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_en;
    logic [NUM_TIMERS-1:0] r_periodic;
    logic [NUM_TIMERS-1:0] r_pending;
    logic [NUM_TIMERS-1:0] r_mask;

    // Address decode: word index inside the 256-byte window
    logic [5:0]            w_word;
    logic                  w_is_ch;
    logic [3:0]            w_ch;
    logic [1:0]            w_reg;
    logic                  w_wr;
    logic [CNT_W-1:0]      w_wd;
    logic [NUM_TIMERS-1:0] w_match;
    logic [NUM_TIMERS-1:0] w_sel;
    logic [NUM_TIMERS-1:0] w_active;
    logic [NUM_TIMERS-1:0] w_clr;
    logic                  w_vec_valid;
    logic [3:0]            w_vec_idx;
    logic                  w_unused;

    assign hit     = (address[31:8] == BASE_ADDR[31:8]);
    assign w_word  = address[7:2];
    assign w_is_ch = (w_word[5:2] != 4'd0);
    assign w_ch    = w_word[5:2] - 4'd1;   // channel i occupies words 4+4i..7+4i
    assign w_reg   = w_word[1:0];
    assign w_wr    = hit & MemWrite;
    assign w_wd    = wr_data[CNT_W-1:0];
    assign w_clr   = (w_wr && w_word == 6'd1) ? wr_data[NUM_TIMERS-1:0] : '0;

    assign w_active = r_pending & r_mask;
    assign irq      = |w_active;

    // Address bits [1:0] and upper store-data bits are intentionally ignored
    assign w_unused = &{1'b0, address[1:0], wr_data};

    generate
        for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
            // Match uses pre-edge COUNT/COMPARE/EN so same-cycle writes cannot mask it
            assign w_match[gi] = r_en[gi] & (r_count == r_compare[gi]);
            assign w_sel[gi]   = w_wr & w_is_ch & (w_ch == 4'(gi));
        end
    endgenerate

    // Free-running counter; a software write replaces the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr && w_word == 6'd0) begin
            r_count <= w_wd;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Pending (match set wins over write-1-to-clear) and mask registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_match;
            if (w_wr && w_word == 6'd2) begin
                r_mask <= wr_data[NUM_TIMERS-1:0];
            end
        end
    end

    // Per-channel compare/period/control; software COMPARE write beats periodic reload
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_compare[i] <= '1;
                r_period[i]  <= '0;
            end
            r_en       <= '0;
            r_periodic <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_sel[i] && w_reg == 2'd0) begin
                    r_compare[i] <= w_wd;
                end else if (w_match[i] && r_periodic[i]) begin
                    r_compare[i] <= r_compare[i] + r_period[i];
                end
                if (w_sel[i] && w_reg == 2'd1) begin
                    r_period[i] <= w_wd;
                end
                if (w_sel[i] && w_reg == 2'd2) begin
                    r_en[i]       <= wr_data[0];
                    r_periodic[i] <= wr_data[1];
                end
            end
        end
    end

    // Priority encoder: lowest active channel index wins
    always_comb begin
        w_vec_valid = 1'b0;
        w_vec_idx   = 4'd0;
        for (int i = NUM_TIMERS - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_valid = 1'b1;
                w_vec_idx   = 4'(i);
            end
        end
    end

    // Read-data mux; unmapped offsets and absent channels return zero
    always_comb begin
        rd_data = 32'd0;
        if (hit && MemRead) begin
            case (w_word)
                6'd0:    rd_data = 32'(r_count);
                6'd1:    rd_data = 32'(r_pending);
                6'd2:    rd_data = 32'(r_mask);
                6'd3:    rd_data = {w_vec_valid, 27'd0, w_vec_idx};
                default: begin
                    for (int i = 0; i < NUM_TIMERS; i++) begin
                        if (w_ch == 4'(i)) begin
                            case (w_reg)
                                2'd0:    rd_data = 32'(r_compare[i]);
                                2'd1:    rd_data = 32'(r_period[i]);
                                2'd2:    rd_data = {30'd0, r_periodic[i], r_en[i]};
                                default: rd_data = 32'd0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
